// File: rtl/asrm_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// asrm_bus_arbiter_if
//   Bundle of every signal between the two bus masters, the arbiter and the
//   single-port system memory.
//
//   Master 0 / master 1 (mX_ prefix):
//     mX_req       access request, held until mX_ready
//     mX_addr      address
//     mX_data_out  write data
//     mX_write_en  1 = write, 0 = read
//     mX_data_in   registered read data returned to the master
//     mX_ready     one-cycle completion pulse
//   Memory side:
//     mem_addr, mem_data_out, mem_write_en   driven by the arbiter
//     mem_data_in                            read data from memory
//   owner          current bus owner: 00 none, 01 m0, 10 m1
//
//   Modports:
//     master  the environment side (both masters plus the memory model)
//     slave   the arbiter side
//
//   Handshake: a master raises mX_req with addr/data/write_en stable and
//   keeps it high until it sees mX_ready for one cycle. A request still high
//   in the cycle after mX_ready is treated as a fresh request.
// ---------------------------------------------------------------------------
interface asrm_bus_arbiter_if #(
  parameter int wordsize = 16
);

  logic                m0_req;
  logic [wordsize-1:0] m0_addr;
  logic [wordsize-1:0] m0_data_out;
  logic                m0_write_en;
  logic [wordsize-1:0] m0_data_in;
  logic                m0_ready;

  logic                m1_req;
  logic [wordsize-1:0] m1_addr;
  logic [wordsize-1:0] m1_data_out;
  logic                m1_write_en;
  logic [wordsize-1:0] m1_data_in;
  logic                m1_ready;

  logic [wordsize-1:0] mem_addr;
  logic [wordsize-1:0] mem_data_out;
  logic                mem_write_en;
  logic [wordsize-1:0] mem_data_in;

  logic [1:0]          owner;

  modport master (
    output m0_req, m0_addr, m0_data_out, m0_write_en,
    input  m0_data_in, m0_ready,
    output m1_req, m1_addr, m1_data_out, m1_write_en,
    input  m1_data_in, m1_ready,
    input  mem_addr, mem_data_out, mem_write_en,
    output mem_data_in,
    input  owner
  );

  modport slave (
    input  m0_req, m0_addr, m0_data_out, m0_write_en,
    output m0_data_in, m0_ready,
    input  m1_req, m1_addr, m1_data_out, m1_write_en,
    output m1_data_in, m1_ready,
    output mem_addr, mem_data_out, mem_write_en,
    input  mem_data_in,
    output owner
  );

endinterface

// File: rtl/asrm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// asrm_bus_arbiter
//   Two-master round-robin arbiter for the single-port asrm system memory.
//   A granted access is latched, presented to memory for mem_latency cycles,
//   read data is captured on the last access cycle and the master receives a
//   one-cycle ready pulse in the following RESPOND cycle.
//
//   Parameters:
//     wordsize     width of address and data words
//     mem_latency  cycles from address to valid mem_data_in (1..7)
//
//   Ports:
//     clk        clock
//     reset      synchronous, active-low
//     bus        asrm_bus_arbiter_if.slave (masters, memory, owner)
//     fsm_state  current FSM state (0 IDLE, 1 ACCESS, 2 RESPOND)
//
//   Transaction timing (request seen at the posedge ending cycle 0):
//     cycles 1..mem_latency  ACCESS, memory driven from latched request
//     cycle  mem_latency+1   RESPOND, ready pulse to the granted master
//     cycle  mem_latency+2   IDLE, next request may be accepted
// ---------------------------------------------------------------------------
module asrm_bus_arbiter #(
  parameter int wordsize    = 16,
  parameter int mem_latency = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  asrm_bus_arbiter_if.slave     bus,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(mem_latency);

  state_t              state;
  state_t              state_nxt;

  // grant: 0 = m0, 1 = m1. prio: master favoured on a tie (0 = m0, 1 = m1).
  logic                grant;
  logic                prio;
  logic [wordsize-1:0] lat_addr;
  logic [wordsize-1:0] lat_data;
  logic                lat_we;
  logic [2:0]          count;
  logic [wordsize-1:0] m0_rdata;
  logic [wordsize-1:0] m1_rdata;

  logic                any_req;
  logic                pick;
  logic                last_access;
  logic                first_access;

  always_comb begin
    any_req      = bus.m0_req | bus.m1_req;
    // Lone requester wins; on a tie the pointer decides.
    pick         = (bus.m0_req & bus.m1_req) ? prio : bus.m1_req;
    last_access  = (count == 3'd1);
    // The counter is loaded with LAT, so it still equals LAT only in the
    // first ACCESS cycle; this qualifies the single-cycle write strobe.
    first_access = (count == LAT);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and bus outputs
  always_comb begin
    state_nxt        = state;
    bus.owner        = 2'b00;
    bus.mem_addr     = '0;
    bus.mem_data_out = '0;
    bus.mem_write_en = 1'b0;
    bus.m0_ready     = 1'b0;
    bus.m1_ready     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        bus.owner        = grant ? 2'b10 : 2'b01;
        bus.mem_addr     = lat_addr;
        bus.mem_data_out = lat_data;
        bus.mem_write_en = lat_we & first_access;
        if (last_access) begin
          state_nxt = RESPOND;
        end
      end
      RESPOND: begin
        bus.owner    = grant ? 2'b10 : 2'b01;
        bus.m0_ready = ~grant;
        bus.m1_ready = grant;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch, latency counter, read-data capture and priority pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant    <= 1'b0;
      prio     <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_we   <= 1'b0;
      count    <= 3'd0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant    <= pick;
            lat_addr <= pick ? bus.m1_addr     : bus.m0_addr;
            lat_data <= pick ? bus.m1_data_out : bus.m0_data_out;
            lat_we   <= pick ? bus.m1_write_en : bus.m0_write_en;
            count    <= LAT;
          end
        end
        ACCESS: begin
          count <= count - 3'd1;
          if (last_access && !lat_we) begin
            if (grant) begin
              m1_rdata <= bus.mem_data_in;
            end else begin
              m0_rdata <= bus.mem_data_in;
            end
          end
        end
        RESPOND: begin
          // The master just served loses the next tie.
          prio <= ~grant;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    bus.m0_data_in = m0_rdata;
    bus.m1_data_in = m1_rdata;
    fsm_state      = state;
  end

endmodule

// File: tb/tb_asrm_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_asrm_bus_arbiter
//   Directed bench for asrm_bus_arbiter. dut2 runs with mem_latency=2, dut1
//   with mem_latency=1. Inputs change 1 ns after a rising edge and outputs
//   are sampled at that point, so each tick() lands in the next cycle.
// ---------------------------------------------------------------------------
module tb_asrm_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] state2;
  logic [1:0] state1;
  int         cyc;
  int         n_checks;
  int         n_fail;
  logic [1:0] exp_q[$];

  asrm_bus_arbiter_if #(.wordsize(16)) bus2 ();
  asrm_bus_arbiter_if #(.wordsize(16)) bus1 ();

  asrm_bus_arbiter #(.wordsize(16), .mem_latency(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .fsm_state(state2)
  );

  asrm_bus_arbiter #(.wordsize(16), .mem_latency(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .fsm_state(state1)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus2.m0_req = 0; bus2.m0_addr = '0; bus2.m0_data_out = '0; bus2.m0_write_en = 0;
    bus2.m1_req = 0; bus2.m1_addr = '0; bus2.m1_data_out = '0; bus2.m1_write_en = 0;
    bus2.mem_data_in = '0;
    bus1.m0_req = 0; bus1.m0_addr = '0; bus1.m0_data_out = '0; bus1.m0_write_en = 0;
    bus1.m1_req = 0; bus1.m1_addr = '0; bus1.m1_data_out = '0; bus1.m1_write_en = 0;
    bus1.mem_data_in = '0;
  endtask

  // scenarios
  task automatic test_reset;
    reset = 1'b0;
    drive_idle();
    repeat (3) tick();
    n_checks++; if ({bus2.owner, bus2.mem_addr, bus2.mem_data_out, bus2.mem_write_en, bus2.m0_data_in, bus2.m0_ready, bus2.m1_data_in, bus2.m1_ready} !== '0) begin n_fail++; $display("FAIL reset_outputs_dut2: got owner=%b addr=%h wdata=%h we=%b d0=%h r0=%b d1=%h r1=%b, expected all 0", bus2.owner, bus2.mem_addr, bus2.mem_data_out, bus2.mem_write_en, bus2.m0_data_in, bus2.m0_ready, bus2.m1_data_in, bus2.m1_ready); end
    n_checks++; if ({bus1.owner, bus1.mem_addr, bus1.mem_data_out, bus1.mem_write_en, bus1.m0_data_in, bus1.m0_ready, bus1.m1_data_in, bus1.m1_ready} !== '0) begin n_fail++; $display("FAIL reset_outputs_dut1: got owner=%b addr=%h we=%b d0=%h r0=%b, expected all 0", bus1.owner, bus1.mem_addr, bus1.mem_write_en, bus1.m0_data_in, bus1.m0_ready); end
    n_checks++; if (state2 !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", state2); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus2.owner !== 2'b00) begin n_fail++; $display("FAIL idle_owner: got %b, expected 00", bus2.owner); end
  endtask

  task automatic test_read;
    bus2.m0_addr = 16'h0010; bus2.m0_write_en = 0; bus2.m0_data_out = 16'h0000;
    bus2.mem_data_in = 16'hBEEF; bus2.m0_req = 1;
    tick(); // cycle 1
    n_checks++; if (bus2.owner !== 2'b01) begin n_fail++; $display("FAIL read_owner_c1: got %b, expected 01", bus2.owner); end
    n_checks++; if (bus2.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL read_addr_c1: got %h, expected 0010", bus2.mem_addr); end
    n_checks++; if (bus2.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL read_we_c1: got %b, expected 0", bus2.mem_write_en); end
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL read_ready_c1: got %b, expected 0", bus2.m0_ready); end
    bus2.m0_addr = 16'hFFFF; // mid-access change must be ignored
    tick(); // cycle 2
    n_checks++; if (bus2.mem_addr !== 16'h0010) begin n_fail++; $display("FAIL read_addr_c2: got %h, expected 0010", bus2.mem_addr); end
    n_checks++; if (bus2.owner !== 2'b01) begin n_fail++; $display("FAIL read_owner_c2: got %b, expected 01", bus2.owner); end
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL read_ready_c2: got %b, expected 0", bus2.m0_ready); end
    tick(); // cycle 3
    n_checks++; if (bus2.m0_ready !== 1'b1) begin n_fail++; $display("FAIL read_ready_c3: got %b, expected 1", bus2.m0_ready); end
    n_checks++; if (bus2.m1_ready !== 1'b0) begin n_fail++; $display("FAIL read_m1_ready_c3: got %b, expected 0", bus2.m1_ready); end
    n_checks++; if (bus2.owner !== 2'b01) begin n_fail++; $display("FAIL read_owner_c3: got %b, expected 01", bus2.owner); end
    n_checks++; if (bus2.m0_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL read_data_c3: got %h, expected beef", bus2.m0_data_in); end
    bus2.m0_req = 0; bus2.mem_data_in = 16'h1111;
    tick(); // cycle 4
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL read_ready_c4: got %b, expected 0", bus2.m0_ready); end
    n_checks++; if (bus2.owner !== 2'b00) begin n_fail++; $display("FAIL read_owner_c4: got %b, expected 00", bus2.owner); end
    tick();
    n_checks++; if (bus2.m0_data_in !== 16'hBEEF) begin n_fail++; $display("FAIL read_data_hold: got %h, expected beef", bus2.m0_data_in); end
    n_checks++; if (state2 !== 2'd0) begin n_fail++; $display("FAIL read_back_idle: got state %0d, expected 0", state2); end
  endtask

  task automatic test_write;
    bus2.m1_addr = 16'h0020; bus2.m1_data_out = 16'h1234; bus2.m1_write_en = 1;
    bus2.mem_data_in = 16'hDEAD; bus2.m1_req = 1;
    tick(); // cycle 1
    n_checks++; if (bus2.mem_write_en !== 1'b1) begin n_fail++; $display("FAIL write_we_c1: got %b, expected 1", bus2.mem_write_en); end
    n_checks++; if (bus2.mem_data_out !== 16'h1234) begin n_fail++; $display("FAIL write_data_c1: got %h, expected 1234", bus2.mem_data_out); end
    n_checks++; if (bus2.mem_addr !== 16'h0020) begin n_fail++; $display("FAIL write_addr_c1: got %h, expected 0020", bus2.mem_addr); end
    n_checks++; if (bus2.owner !== 2'b10) begin n_fail++; $display("FAIL write_owner_c1: got %b, expected 10", bus2.owner); end
    tick(); // cycle 2
    n_checks++; if (bus2.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL write_we_c2: got %b, expected 0", bus2.mem_write_en); end
    n_checks++; if (bus2.m1_ready !== 1'b0) begin n_fail++; $display("FAIL write_ready_c2: got %b, expected 0", bus2.m1_ready); end
    tick(); // cycle 3
    n_checks++; if (bus2.m1_ready !== 1'b1) begin n_fail++; $display("FAIL write_ready_c3: got %b, expected 1", bus2.m1_ready); end
    n_checks++; if (bus2.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL write_we_c3: got %b, expected 0", bus2.mem_write_en); end
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL write_m0_ready_c3: got %b, expected 0", bus2.m0_ready); end
    n_checks++; if (bus2.m1_data_in !== 16'h0000) begin n_fail++; $display("FAIL write_data_in_kept: got %h, expected 0000", bus2.m1_data_in); end
    bus2.m1_req = 0;
    tick();
    n_checks++; if (bus2.m1_ready !== 1'b0) begin n_fail++; $display("FAIL write_ready_c4: got %b, expected 0", bus2.m1_ready); end
  endtask

  task automatic test_back_to_back;
    int         got;
    int         prev;
    int         gap_exp;
    logic [1:0] who;
    logic [1:0] exp;
    exp_q = {2'b01, 2'b10, 2'b01, 2'b10};
    bus2.m0_addr = 16'h0040; bus2.m0_write_en = 0;
    bus2.m1_addr = 16'h0050; bus2.m1_write_en = 1; bus2.m1_data_out = 16'hAAAA;
    bus2.mem_data_in = 16'h4242;
    bus2.m0_req = 1; bus2.m1_req = 1;
    got = 0; prev = cyc; gap_exp = 3;
    for (int i = 0; i < 40 && got < 4; i++) begin
      tick();
      n_checks++; if (bus2.m0_ready && bus2.m1_ready) begin n_fail++; $display("FAIL b2b_both_ready: got 11, expected at most one"); end
      if (bus2.m0_ready || bus2.m1_ready) begin
        who = {bus2.m1_ready, bus2.m0_ready};
        exp = exp_q.pop_front();
        n_checks++; if (who !== exp) begin n_fail++; $display("FAIL b2b_order_%0d: got %b, expected %b", got, who, exp); end
        n_checks++; if (cyc - prev !== gap_exp) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d, expected %0d", got, cyc - prev, gap_exp); end
        prev = cyc; gap_exp = 4; got++;
        if (got == 4) begin bus2.m0_req = 0; bus2.m1_req = 0; end
      end
    end
    n_checks++; if (got !== 4) begin n_fail++; $display("FAIL b2b_timeout: got %0d readies, expected 4", got); end
    n_checks++; if (bus2.m0_data_in !== 16'h4242) begin n_fail++; $display("FAIL b2b_m0_data: got %h, expected 4242", bus2.m0_data_in); end
    bus2.m0_req = 0; bus2.m1_req = 0;
    tick();
  endtask

  task automatic test_round_robin;
    int         got;
    int         prev;
    logic [1:0] who;
    logic [1:0] exp;
    bus2.m1_addr = 16'h0060; bus2.m1_data_out = 16'h0BAD; bus2.m1_write_en = 1;
    bus2.m0_addr = 16'h0070; bus2.m0_write_en = 0;
    bus2.mem_data_in = 16'h5A5A;
    bus2.m1_req = 1;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus2.m1_ready) got = 1;
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL rr_first_m1_timeout: got %0d readies, expected 1", got); end
    prev = cyc;
    tick(); // IDLE, m1 still requesting
    tick(); // second m1 access
    n_checks++; if (bus2.owner !== 2'b10) begin n_fail++; $display("FAIL rr_m1_regrant: got %b, expected 10", bus2.owner); end
    bus2.m0_req = 1;
    exp_q = {2'b10, 2'b01};
    got = 0;
    for (int i = 0; i < 20 && got < 2; i++) begin
      tick();
      if (bus2.m0_ready || bus2.m1_ready) begin
        who = {bus2.m1_ready, bus2.m0_ready};
        exp = exp_q.pop_front();
        n_checks++; if (who !== exp) begin n_fail++; $display("FAIL rr_order_%0d: got %b, expected %b", got, who, exp); end
        n_checks++; if (cyc - prev !== 4) begin n_fail++; $display("FAIL rr_gap_%0d: got %0d, expected 4", got, cyc - prev); end
        prev = cyc; got++;
        if (got == 2) begin bus2.m0_req = 0; bus2.m1_req = 0; end
      end
    end
    n_checks++; if (got !== 2) begin n_fail++; $display("FAIL rr_timeout: got %0d readies, expected 2", got); end
    n_checks++; if (bus2.m0_data_in !== 16'h5A5A) begin n_fail++; $display("FAIL rr_m0_data: got %h, expected 5a5a", bus2.m0_data_in); end
    bus2.m0_req = 0; bus2.m1_req = 0;
    tick();
  endtask

  task automatic test_reset_abort;
    int got;
    // last grant went to m0, so the pointer now favours m1 until reset
    bus2.m0_addr = 16'h0080; bus2.m0_write_en = 0; bus2.mem_data_in = 16'h7777;
    bus2.m1_addr = 16'h0090; bus2.m1_write_en = 1; bus2.m1_data_out = 16'h0001;
    bus2.m0_req = 1;
    tick(); // ACCESS of m0 read
    n_checks++; if (bus2.owner !== 2'b01) begin n_fail++; $display("FAIL abort_owner_pre: got %b, expected 01", bus2.owner); end
    reset = 1'b0; bus2.m1_req = 1;
    tick();
    n_checks++; if (bus2.owner !== 2'b00) begin n_fail++; $display("FAIL abort_owner: got %b, expected 00", bus2.owner); end
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready: got %b, expected 0", bus2.m0_ready); end
    n_checks++; if (bus2.m0_data_in !== 16'h0000) begin n_fail++; $display("FAIL abort_data_in: got %h, expected 0000", bus2.m0_data_in); end
    n_checks++; if (bus2.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL abort_mem_addr: got %h, expected 0000", bus2.mem_addr); end
    tick();
    n_checks++; if (bus2.m0_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready_late: got %b, expected 0", bus2.m0_ready); end
    reset = 1'b1;
    tick();
    n_checks++; if (bus2.owner !== 2'b01) begin n_fail++; $display("FAIL abort_tie_m0: got %b, expected 01", bus2.owner); end
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (bus2.m0_ready || bus2.m1_ready) begin
        got = 1;
        n_checks++; if (bus2.m0_ready !== 1'b1) begin n_fail++; $display("FAIL abort_first_ready: got m0=%b m1=%b, expected m0", bus2.m0_ready, bus2.m1_ready); end
        bus2.m0_req = 0; bus2.m1_req = 0;
      end
    end
    n_checks++; if (got !== 1) begin n_fail++; $display("FAIL abort_timeout: got %0d readies, expected 1", got); end
    n_checks++; if (bus2.m0_data_in !== 16'h7777) begin n_fail++; $display("FAIL abort_reread: got %h, expected 7777", bus2.m0_data_in); end
    bus2.m0_req = 0; bus2.m1_req = 0;
    tick();
  endtask

  task automatic test_latency1;
    logic [15:0] vals[4];
    int          k;
    int          prev;
    int          gap_exp;
    vals = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    bus1.m0_addr = 16'h00A0; bus1.m0_write_en = 0; bus1.mem_data_in = vals[0];
    bus1.m0_req = 1;
    k = 0; prev = cyc; gap_exp = 2;
    for (int i = 0; i < 30 && k < 4; i++) begin
      tick();
      n_checks++; if (bus1.mem_write_en !== 1'b0) begin n_fail++; $display("FAIL lat1_we: got %b, expected 0", bus1.mem_write_en); end
      if (bus1.m0_ready) begin
        n_checks++; if (bus1.m0_data_in !== vals[k]) begin n_fail++; $display("FAIL lat1_data_%0d: got %h, expected %h", k, bus1.m0_data_in, vals[k]); end
        n_checks++; if (cyc - prev !== gap_exp) begin n_fail++; $display("FAIL lat1_gap_%0d: got %0d, expected %0d", k, cyc - prev, gap_exp); end
        prev = cyc; gap_exp = 3; k++;
        if (k < 4) bus1.mem_data_in = vals[k];
        else bus1.m0_req = 0;
      end
    end
    n_checks++; if (k !== 4) begin n_fail++; $display("FAIL lat1_timeout: got %0d readies, expected 4", k); end
    bus1.m0_req = 0;
    tick();
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    drive_idle();
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_round_robin();
    test_reset_abort();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/asrm_bus_arbiter.md
Name: asrm_bus_arbiter

Overview:
- Two-master arbiter for the single-port system memory bus (addr / data_out / data_in / write_en) used by asrm_cpu.
- Shares one memory between master 0 (CPU) and master 1 (DMA or debug port) using round-robin priority.
- Sequences each access over a fixed memory read latency and returns a one-cycle ready pulse to the served master.

Parameters:
- wordsize, 16: width of address and data words.
- mem_latency, 1: cycles from address presentation to valid mem_data_in; legal range 1..7.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low.
- m0_req  in  1  master 0 access request; held until m0_ready.
- m0_addr  in  wordsize  master 0 address.
- m0_data_out  in  wordsize  master 0 write data.
- m0_write_en  in  1  master 0 write (1) / read (0).
- m0_data_in  out  wordsize  master 0 read data, registered.
- m0_ready  out  1  master 0 transaction complete pulse.
- m1_req, m1_addr, m1_data_out, m1_write_en, m1_data_in, m1_ready: identical set for master 1.
- mem_addr  out  wordsize  memory address.
- mem_data_out  out  wordsize  memory write data.
- mem_write_en  out  1  memory write strobe.
- mem_data_in  in  wordsize  memory read data.
- owner  out  2  current bus owner: 00 none, 01 m0, 10 m1.

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0, including mX_data_in; priority pointer favours m0. Reset aborts any in-flight access with no ready pulse.
- States: IDLE, ACCESS, RESPOND.
- IDLE:
  - owner=00; mem_* outputs 0.
  - If any req is high at posedge: choose a master, latch its addr, data_out and write_en into internal registers, load counter=mem_latency, go to ACCESS.
  - If only one master requests, it wins.
  - If both request, the master not served last wins; after reset m0 wins the first tie.
- ACCESS:
  - mem_addr and mem_data_out driven from latched registers; owner = the granted master.
  - mem_write_en=1 only in the first ACCESS cycle, and only if the access is a write. It is never high in any other cycle or state.
  - Counter decrements each cycle; when counter==1 at posedge, go to RESPOND.
  - On that same posedge, a read captures mem_data_in into the granted mX_data_in.
  - Request inputs and the other master are ignored during ACCESS; mid-transaction changes to the granted master's inputs have no effect.
- RESPOND:
  - Granted mX_ready=1 for exactly this cycle; owner still valid.
  - Priority pointer updated to favour the other master.
  - Go to IDLE.
- Timing:
  - Request seen at posedge of cycle 0 → ACCESS cycles 1..mem_latency → ready in cycle mem_latency+1 → IDLE in mem_latency+2.
  - Throughput is one transaction per mem_latency+2 cycles.
- mX_data_in holds its last read value until the next read by that master. Writes leave it unchanged but still pulse ready.
- If a master keeps req high in the IDLE cycle after its ready, that is a new request.
- m0_ready and m1_ready are never high in the same cycle. No starvation: with both masters requesting continuously, grants strictly alternate.

Test Plan:
- mem_latency=2; m0 read addr 0x0010, memory returns 0xBEEF → mem_addr=0x0010 in cycles 1–2, m0_ready high in cycle 3 only, m0_data_in=0xBEEF, owner=01 cycles 1–3.
- m1 write addr 0x0020, data 0x1234 → mem_write_en high exactly one cycle (cycle 1) with mem_data_out=0x1234, m1_ready in cycle mem_latency+1, m1_data_in unchanged.
- Both req asserted simultaneously and held continuously after reset → grant order m0, m1, m0, m1; ready pulses alternate, spaced mem_latency+2 cycles.
- m1 requests alone repeatedly, then m0 asserts while m1 is in ACCESS → m1 completes first, then m0 served next even though m1 is still requesting.
- reset deasserted→asserted low during ACCESS of an m0 read → next cycle all outputs 0, no m0_ready pulse, owner=00. After release, a pending m1 and m0 tie is granted to m0.
- mem_latency=1, m0 read held continuously → ready every 3 cycles, m0_data_in updates each time to the current mem_data_in value.
